apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- Parametrised APB (AMBA3) completer with an internal register file.
- Supports configurable address/data width, register count and a fixed number of wait states per access.
- Flags out-of-range, misaligned and read-only writes with pslverr.
- Sits on the APB bus driven by the existing APB interface/driver. Register contents are exported flat to the surrounding logic, with a one-cycle write strobe per register.

Parameters:
- ADD_WIDTH, 8, APB address width in bits; byte addressing.
- DATA_WIDTH, 32, data width in bits; must be 8, 16 or 32.
- NUM_REGS, 8, number of word registers; must satisfy 2 <= NUM_REGS <= 2^(ADD_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, number of extra access cycles before pready; range 0..15.
- ID_VALUE, 32'hA5B0_0001, read-only value of register 0; truncated to DATA_WIDTH.

Ports:
- top_clk  in  1  bus clock; all logic on posedge.
- prst  in  1  asynchronous active-low reset.
- psel  in  1  completer select.
- penable  in  1  access phase.
- pwr  in  1  1 = write, 0 = read.
- padd  in  ADD_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error; valid only with pready.
- sts_in  in  DATA_WIDTH  hardware status; read-only at register 1.
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg k at [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle pulse per register on a committed write.

Behaviour:
- Reset (prst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - Registers 2..NUM_REGS-1 = 0.
  - prdata=0, pready=0, pslverr=0, wr_pulse=0.
- Address decode:
  - idx = padd >> log2(DATA_WIDTH/8).
  - misaligned = any of padd's low log2(DATA_WIDTH/8) bits set.
  - err = misaligned | (idx >= NUM_REGS) | (pwr & idx<2).
- Register map:
  - reg0 = ID_VALUE, read-only.
  - reg1 = sts_in, sampled combinationally on read, read-only.
  - reg2..: R/W storage.
- FSM state IDLE:
  - On posedge with psel=1, penable=0 (setup phase): latch padd, pwr, pwdata, err; load cnt=WAIT_STATES; go to ACCESS.
  - Any other input: stay in IDLE. penable without a setup phase is ignored.
- FSM state ACCESS:
  - pready = (cnt==0), combinational from state and cnt.
  - If psel=1, penable=1 and cnt!=0: decrement cnt.
  - If psel=1, penable=1 and cnt==0: transfer completes at this edge; go to IDLE.
  - If psel=0: abort, go to IDLE, no write committed, no wr_pulse.
- Latency: access phase lasts WAIT_STATES+1 cycles. WAIT_STATES=0 gives a 2-cycle APB transfer.
- Back-to-back: after completion the FSM is in IDLE and accepts the next setup phase on the following cycle. There are no dead cycles beyond the protocol's.
- Write commit: at the completion edge, if pwr=1 and !err:
  - reg[idx] <= pwdata.
  - wr_pulse[idx] = 1 for the next cycle.
  - On err, nothing changes and wr_pulse stays 0.
- Read data: prdata = reg value (or sts_in / ID_VALUE) only while state=ACCESS, pready=1, pwr=0 and !err. Otherwise prdata = 0.
- pslverr = pready & err; 0 at all other times.
- Input stability: pwdata/padd changes during ACCESS are ignored because the latched copies are used.
- Reset mid-transfer: the transfer is aborted immediately. pready falls asynchronously. No partial write.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - Adds input pstrb, width DATA_WIDTH/8, latched in the setup phase.
  - A committed write updates only the byte lanes with pstrb[i]=1.
  - A write with pstrb=0 completes without error and leaves the register unchanged, but wr_pulse still fires.
  - On reads, pstrb must be 0; a read with nonzero pstrb gives pslverr=1.
- Undefined: no pstrb port; every write updates the full word.

Test Plan:
- Reset -> reg_q=0 for regs 2..7, prdata=0, pready=0, pslverr=0. Read addr 0x00 -> prdata=0xA5B00001, pslverr=0.
- WAIT_STATES=0: write 0xDEADBEEF to 0x08, then read 0x08.
  - pready high on the first access cycle.
  - reg_q[2]=0xDEADBEEF; wr_pulse[2] high exactly 1 cycle.
  - Read returns 0xDEADBEEF.
- WAIT_STATES=3: read 0x0C -> pready low for 3 access cycles, high on the 4th; transfer takes 5 cycles total.
- Error cases, each -> pslverr=1 with pready, reg_q unchanged, wr_pulse=0:
  - Write to 0x04 (sts register, read-only).
  - Write to 0x20 (idx 8 >= NUM_REGS).
  - Read from 0x09 (misaligned).
- Abort cases:
  - psel dropped during the wait states of a write to 0x10 -> no update, FSM in IDLE; the next transfer succeeds.
  - prst pulsed low mid-access -> all outputs at reset values.
- APB_PSTRB_EN: reg2=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> reg2=0x11BB33DD.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB3 completer with a small register file: ID (ro), status (ro), then R/W words.
// Optional byte-lane write strobes are enabled by defining APB_PSTRB_EN.
module apb_regfile_slave #(
    parameter int unsigned ADD_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           top_clk,
    input  logic                           prst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwr,
    input  logic [ADD_WIDTH-1:0]           padd,
    input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [DATA_WIDTH-1:0]          sts_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned LSB_W = $clog2(NB);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADD_WIDTH-1:0]   idx_q, idx_d;
    logic                   pwr_q, pwr_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;
`ifdef APB_PSTRB_EN
    logic [NB-1:0]          strb_q, strb_d;
`endif

    logic [ADD_WIDTH-1:0]   idx_c;
    logic                   misalign_c;
    logic                   err_c;

    // Setup-phase decode; the result is latched so ACCESS ignores bus changes.
    always_comb begin
        idx_c      = padd >> LSB_W;
        misalign_c = (padd & ADD_WIDTH'(NB - 1)) != '0;
        err_c      = misalign_c
                   | (32'(idx_c) >= NUM_REGS)
                   | (pwr & (idx_c < ADD_WIDTH'(2)));
`ifdef APB_PSTRB_EN
        err_c      = err_c | (~pwr & (pstrb != '0));
`endif
    end

    // Registers 0 and 1 are not storage: ID constant and live status.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_exp
        if (g == 0) begin : g_id
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(ID_VALUE);
        end else if (g == 1) begin : g_sts
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = sts_in;
        end else begin : g_rw
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    end

    assign pready   = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr  = pready & err_q;
    assign wr_pulse = wr_pulse_q;

    always_comb begin
        prdata = '0;
        if (pready && !pwr_q && !err_q) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (idx_q == ADD_WIDTH'(k)) begin
                    prdata = reg_q[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state, wait counting and write commit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pwr_d      = pwr_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
`ifdef APB_PSTRB_EN
        strb_d     = strb_q;
`endif
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    idx_d   = idx_c;
                    pwr_d   = pwr;
                    err_d   = err_c;
                    wdata_d = pwdata;
`ifdef APB_PSTRB_EN
                    strb_d  = pstrb;
`endif
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        if (pwr_q && !err_q) begin
                            for (int unsigned k = 2; k < NUM_REGS; k++) begin
                                if (idx_q == ADD_WIDTH'(k)) begin
`ifdef APB_PSTRB_EN
                                    for (int unsigned b = 0; b < NB; b++) begin
                                        if (strb_q[b]) begin
                                            regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                                        end
                                    end
`else
                                    regs_d[k] = wdata_q;
`endif
                                    wr_pulse_d[k] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge top_clk or negedge prst) begin
        if (!prst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pwr_q      <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
`ifdef APB_PSTRB_EN
            strb_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pwr_q      <= pwr_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
`ifdef APB_PSTRB_EN
            strb_q     <= strb_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: two instances (0 and 3 wait states) on a shared bus,
// directed steps followed by random transfers checked against an array model.
module tb_apb_regfile_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, psel, penable, pwr;
    logic [7:0]   padd;
    logic [31:0]  pwdata, sts_in;
    bit           use3;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [255:0] regq0, regq3;
    logic [7:0]   wp0, wp3;
`ifdef APB_PSTRB_EN
    logic [3:0]   pstrb;
    logic [3:0]   strb_w = 4'hF;
`endif

    apb_regfile_slave #(.WAIT_STATES(0)) u_ws0 (
        .top_clk(clk), .prst(rst_n), .psel(psel & ~use3), .penable(penable),
        .pwr(pwr), .padd(padd), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .sts_in(sts_in), .reg_q(regq0), .wr_pulse(wp0));

    apb_regfile_slave #(.WAIT_STATES(3)) u_ws3 (
        .top_clk(clk), .prst(rst_n), .psel(psel & use3), .penable(penable),
        .pwr(pwr), .padd(padd), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .sts_in(sts_in), .reg_q(regq3), .wr_pulse(wp3));

    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [255:0] regq;
    logic [7:0]   wp;
    assign prdata  = use3 ? prdata3  : prdata0;
    assign pready  = use3 ? pready3  : pready0;
    assign pslverr = use3 ? pslverr3 : pslverr0;
    assign regq    = use3 ? regq3    : regq0;
    assign wp      = use3 ? wp3      : wp0;

    logic [31:0] mdl [2][8];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_regs(input int w);
        logic [255:0] v;
        for (int k = 0; k < 8; k++)
            v[k*32 +: 32] = (k == 0) ? ID : (k == 1) ? sts_in : mdl[w][k];
        return v;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 8; k++) mdl[w][k] = '0;
    endtask

    // One complete APB transfer; reports access-phase length in cycles.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic err, output int acc, output bit to);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwr = wr; padd = addr; pwdata = data;
`ifdef APB_PSTRB_EN
        pstrb = wr ? strb_w : 4'h0;
`endif
        @(posedge clk); #1;
        penable = 1'b1;
        acc = 1; to = 1'b0;
        while (pready !== 1'b1) begin
            if (acc > 40) begin to = 1'b1; break; end
            @(posedge clk); #1;
            acc++;
        end
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        padd = 8'hFF; pwdata = 32'hBAD0_BAD0;
    endtask

    // Transfer plus checks against the rules-derived model.
    task automatic do_xfer(input string tag, input bit wr, input logic [7:0] addr, input logic [31:0] data);
        int          w, idx, acc;
        bit          mis, e, to;
        logic [31:0] erd, rd;
        logic [7:0]  ewp;
        logic        err;
        w   = use3 ? 1 : 0;
        idx = int'(addr) / 4;
        mis = (addr % 4) != 0;
        e   = mis || idx >= 8 || (wr && idx < 2);
        erd = 32'h0;
        if (!wr && !e) erd = (idx == 0) ? ID : (idx == 1) ? sts_in : mdl[w][idx];
        ewp = 8'h00;
        if (wr && !e) ewp[idx] = 1'b1;
        xfer(wr, addr, data, rd, err, acc, to);
        chk({tag, ".timeout"}, 256'(to), 256'(0));
        chk({tag, ".latency"}, 256'(acc), 256'(use3 ? 4 : 1));
        chk({tag, ".pslverr"}, 256'(err), 256'(e));
        chk({tag, ".prdata"}, 256'(rd), 256'(erd));
        chk({tag, ".wr_pulse"}, 256'(wp), 256'(ewp));
        if (wr && !e) mdl[w][idx] = data;
        chk({tag, ".reg_q"}, regq, exp_regs(w));
    endtask

    initial begin
        logic [7:0] a;
        logic [31:0] rd;
        logic err;
        int acc;
        bit to;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwr = 1'b0;
        padd = '0; pwdata = '0; sts_in = 32'h1357_9BDF; use3 = 1'b0;
`ifdef APB_PSTRB_EN
        pstrb = '0;
`endif
        model_reset();
        #12;
        for (int u = 0; u < 2; u++) begin
            use3 = (u == 1); #1;
            chk("rst.pready", 256'(pready), 256'(0));
            chk("rst.pslverr", 256'(pslverr), 256'(0));
            chk("rst.prdata", 256'(prdata), 256'(0));
            chk("rst.wr_pulse", 256'(wp), 256'(0));
            chk("rst.reg_q", regq, exp_regs(u));
        end
        @(posedge clk); #1; rst_n = 1'b1;

        use3 = 1'b0;
        do_xfer("id_rd", 1'b0, 8'h00, 32'h0);
        do_xfer("wr08", 1'b1, 8'h08, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("wr08.pulse_len", 256'(wp), 256'(0));
        do_xfer("rd08", 1'b0, 8'h08, 32'h0);
        do_xfer("sts_rd", 1'b0, 8'h04, 32'h0);

        use3 = 1'b1;
        do_xfer("ws3_rd0c", 1'b0, 8'h0C, 32'h0);
        do_xfer("ws3_wr0c", 1'b1, 8'h0C, 32'h0BAD_F00D);
        do_xfer("ws3_rd0c2", 1'b0, 8'h0C, 32'h0);

        use3 = 1'b0;
        do_xfer("err_wr04", 1'b1, 8'h04, 32'h1111_1111);
        do_xfer("err_wr20", 1'b1, 8'h20, 32'h2222_2222);
        do_xfer("err_rd09", 1'b0, 8'h09, 32'h0);
        do_xfer("err_wr0a", 1'b1, 8'h0A, 32'h3333_3333);

        // Abort a write during its wait states.
        use3 = 1'b1;
        do_xfer("pre_abort", 1'b1, 8'h10, 32'h4444_4444);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwr = 1'b1; padd = 8'h10; pwdata = 32'h5555_5555;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        chk("abort.pready_wait", 256'(pready), 256'(0));
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort.pready", 256'(pready), 256'(0));
        chk("abort.wr_pulse", 256'(wp), 256'(0));
        chk("abort.reg_q", regq, exp_regs(1));
        do_xfer("post_abort_wr", 1'b1, 8'h10, 32'h6666_6666);
        do_xfer("post_abort_rd", 1'b0, 8'h10, 32'h0);

        // Reset while pready is high on the zero-wait instance.
        use3 = 1'b0;
        do_xfer("pre_rst", 1'b1, 8'h14, 32'h7777_7777);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwr = 1'b1; padd = 8'h18; pwdata = 32'h8888_8888;
        @(posedge clk); #1; penable = 1'b1;
        chk("midrst.pready_before", 256'(pready), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.pready", 256'(pready), 256'(0));
        chk("midrst.pslverr", 256'(pslverr), 256'(0));
        chk("midrst.prdata", 256'(prdata), 256'(0));
        chk("midrst.wr_pulse", 256'(wp), 256'(0));
        chk("midrst.reg_q", regq, exp_regs(0));
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst.after", regq, exp_regs(0));
        do_xfer("post_rst_rd", 1'b0, 8'h18, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            use3   = $urandom_range(0, 1) == 1;
            sts_in = $urandom;
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 7) * 4);
                1: a = 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                2: a = 8'($urandom_range(8, 63) * 4);
                default: a = 8'($urandom_range(2, 7) * 4);
            endcase
            do_xfer("rnd", $urandom_range(0, 1) == 1, a, $urandom);
        end

`ifdef APB_PSTRB_EN
        use3 = 1'b0;
        do_xfer("strb_full", 1'b1, 8'h08, 32'h1122_3344);
        strb_w = 4'b0101;
        xfer(1'b1, 8'h08, 32'hAABB_CCDD, rd, err, acc, to);
        chk("strb.err", 256'(err), 256'(0));
        chk("strb.reg2", 256'(regq[64 +: 32]), 256'(32'h11BB_33DD));
        mdl[0][2] = 32'h11BB_33DD;
        strb_w = 4'h0;
        xfer(1'b1, 8'h08, 32'hFFFF_FFFF, rd, err, acc, to);
        chk("strb0.pulse", 256'(wp), 256'(8'h04));
        chk("strb0.reg_q", regq, exp_regs(0));
        strb_w = 4'hF;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwr = 1'b0; padd = 8'h08; pstrb = 4'h1;
        @(posedge clk); #1; penable = 1'b1;
        chk("strb_rd.pslverr", 256'(pslverr), 256'(1));
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pstrb = 4'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

endmodule
